// File: rtl/decos_suma.sv
// decos_suma: per-group ones counts (saturating fields) plus an exact total of ones.
// Define DECOS_SUMA_PIPE_EN for the two-stage build (latency 2); default latency is 1.
module decos_suma #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    localparam int CW     = OSF / 2,
    localparam int TW     = $clog2(SAMPLES * OSF) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [SAMPLES*OSF-1:0]    Input,
    output logic                      out_valid,
    output logic [SAMPLES*CW-1:0]     Output,
    output logic [TW-1:0]             Total
);

    localparam int PW     = $clog2(OSF + 1);
    localparam int LEVELS = $clog2(SAMPLES);
    localparam int LEAVES = 1 << LEVELS;
    localparam int FMAX   = (1 << CW) - 1;

    logic [PW-1:0]         cnt_c   [SAMPLES];
    logic [PW-1:0]         cnt_src [SAMPLES];
    logic                  take;
    logic [SAMPLES*CW-1:0] field_c;
    logic [TW-1:0]         total_c;

    always_comb begin
        for (int k = 0; k < SAMPLES; k++) begin
            cnt_c[k] = PW'($countones(Input[k*OSF +: OSF]));
        end
    end

`ifdef DECOS_SUMA_PIPE_EN
    logic [PW-1:0] cnt_q [SAMPLES];
    logic          valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            for (int k = 0; k < SAMPLES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                cnt_q <= cnt_c;
            end
        end
    end

    assign cnt_src = cnt_q;
    assign take    = valid_q;
`else
    assign cnt_src = cnt_c;
    assign take    = in_valid;
`endif

    // Fields saturate only when CW is too narrow for OSF; the total uses raw counts.
    always_comb begin
        field_c = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            field_c[k*CW +: CW] = (int'(cnt_src[k]) > FMAX) ? {CW{1'b1}} : CW'(cnt_src[k]);
        end
    end

    // Balanced adder tree, padded to a power of two; each level grows by one bit.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LEAVES >> l;
        logic [PW+l-1:0] node [N];

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int j = 0; j < N; j++) begin
                    node[j] = '0;
                end
                for (int j = 0; j < SAMPLES; j++) begin
                    node[j] = cnt_src[j];
                end
            end
        end else begin : g_add
            always_comb begin
                for (int j = 0; j < N; j++) begin
                    node[j] = {1'b0, g_lvl[l-1].node[2*j]} + {1'b0, g_lvl[l-1].node[2*j+1]};
                end
            end
        end
    end

    assign total_c = TW'(g_lvl[LEVELS].node[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Output    <= '0;
            Total     <= '0;
        end else begin
            out_valid <= take;
            if (take) begin
                Output <= field_c;
                Total  <= total_c;
            end
        end
    end

endmodule

// File: tb/tb_decos_suma.sv
// tb_decos_suma: directed checks of decos_suma at defaults plus a saturating 4x4 instance.
module tb_decos_suma;

    localparam int SAMPLES = 128;
    localparam int OSF     = 8;
    localparam int CW      = OSF / 2;
    localparam int TW      = 11;
    localparam int OW      = SAMPLES * CW;
`ifdef DECOS_SUMA_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic [SAMPLES*OSF-1:0] data_in;
    logic                   out_valid;
    logic [OW-1:0]          data_out;
    logic [TW-1:0]          total;

    logic                   in_valid_s;
    logic [15:0]            data_in_s;
    logic                   out_valid_s;
    logic [7:0]             data_out_s;
    logic [4:0]             total_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decos_suma dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Input     (data_in),
        .out_valid (out_valid),
        .Output    (data_out),
        .Total     (total)
    );

    decos_suma #(.SAMPLES(4), .OSF(4)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s),
        .Input     (data_in_s),
        .out_valid (out_valid_s),
        .Output    (data_out_s),
        .Total     (total_s)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ones(input logic [31:0] v);
        int n = 0;
        for (int b = 0; b < 32; b++) n += int'(v[b]);
        return n;
    endfunction

    task automatic send_one(input string tag, input logic [SAMPLES*OSF-1:0] value,
                            input logic [511:0] exp_out, input logic [511:0] exp_tot);
        data_in  = value;
        in_valid = 1'b1;
        for (int c = 0; c <= LAT + 1; c++) begin
            tick();
            in_valid = 1'b0;
            check({tag, "_vld"}, 512'(out_valid), 512'(c == LAT - 1));
            if (c == LAT - 1) begin
                check({tag, "_out"}, 512'(data_out), exp_out);
                check({tag, "_tot"}, 512'(total), exp_tot);
            end
        end
    endtask

    initial begin
        logic [OW-1:0] all_eight;
        logic [15:0]   pat_in;
        logic [511:0]  exp_o;
        int            idx;

        all_eight = {SAMPLES{4'h8}};
        pat_in    = 16'b0000_0000_0000_0101;

        // Reset held with active stimulus: everything stays cleared.
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        data_in    = '1;
        in_valid_s = 1'b1;
        data_in_s  = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_vld", 512'(out_valid), 512'(0));
            check("rst_out", 512'(data_out), 512'(0));
            check("rst_tot", 512'(total), 512'(0));
            check("rst_vld_s", 512'(out_valid_s), 512'(0));
        end
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_vld", 512'(out_valid), 512'(0));

        // Saturating 4x4 instance: counts {4,3,3,1} -> fields {3,3,3,1}, total 11.
        data_in_s  = 16'hF7E1;
        in_valid_s = 1'b1;
        for (int c = 0; c <= LAT; c++) begin
            tick();
            in_valid_s = 1'b0;
            check("sat_vld", 512'(out_valid_s), 512'(c == LAT - 1));
            if (c == LAT - 1) begin
                check("sat_out", 512'(data_out_s), 512'(8'b11_11_11_01));
                check("sat_tot", 512'(total_s), 512'(11));
            end
        end

        send_one("single", 1024'hFF, 512'h8, 512'(8));
        send_one("bound", 1024'h1FF, 512'h18, 512'(9));
        send_one("ones", '1, 512'(all_eight), 512'(1024));
        send_one("zeros", '0, 512'(0), 512'(0));

        // Back-to-back sweep of 0..511, one result per cycle in order.
        for (int c = 0; c < 512 + LAT; c++) begin
            if (c < 512) begin
                data_in      = '0;
                data_in[8:0] = 9'(c);
                in_valid     = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            idx = c - (LAT - 1);
            if (idx >= 0) begin
                check("sweep_vld", 512'(out_valid), 512'(idx < 512));
                if (idx < 512) begin
                    exp_o = 512'(((idx >> 8) & 1) << 4) | 512'(ones(32'(idx & 255)));
                    check("sweep_out", 512'(data_out), exp_o);
                    check("sweep_tot", 512'(total), 512'(ones(32'(idx))));
                end
            end
        end
        in_valid = 1'b0;
        tick();

        // Gap: in_valid 1,0,1 -> out_valid 1,0,1, first result held through the gap.
        for (int c = 0; c < 3 + LAT; c++) begin
            in_valid = (c < 3) ? pat_in[c] : 1'b0;
            data_in  = (c == 0) ? 1024'hFF : 1024'h3;
            tick();
            idx = c - (LAT - 1);
            if (idx >= 0 && idx < 3) begin
                check("gap_vld", 512'(out_valid), 512'(pat_in[idx]));
                check("gap_out", 512'(data_out), (idx < 2) ? 512'h8 : 512'h2);
                check("gap_tot", 512'(total), (idx < 2) ? 512'(8) : 512'(2));
            end
        end
        tick();

        // Reset pulse while a result is in flight: it must never appear.
        data_in  = '1;
        in_valid = 1'b1;
        for (int c = 0; c < LAT - 1; c++) begin
            tick();
            in_valid = 1'b0;
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out", 512'(data_out), 512'(0));
        check("midrst_tot", 512'(total), 512'(0));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("midrst_vld", 512'(out_valid), 512'(0));
        end

        send_one("after_rst", 1024'h1FF, 512'h18, 512'(9));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
